// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the arbitrated on-chip memory.
package mem_arb_pkg;

  // Widest word the response struct can carry; narrower memories use the low bits.
  localparam int unsigned MaxDataWidth = 128;

  localparam logic ErrNone   = 1'b0;
  localparam logic ErrAccess = 1'b1;

  typedef struct packed {
    logic [MaxDataWidth-1:0] rdata;
    logic                    err;
  } rsp_t;

  function automatic int unsigned addr_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  function automatic int unsigned lane_count(input int unsigned data_width);
    return (data_width + 7) / 8;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the request vector, searching upward from a
// priority pointer that moves just past the last granted port.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] cand;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    if (!rst_i) begin
      for (int i = 0; i < int'(N); i++) begin
        cand = PW'((int'(ptr_q) + i) % int'(N));
        if (!gnt_valid_o && req_i[cand]) begin
          gnt_o[cand] = 1'b1;
          gnt_idx_o   = cand;
          gnt_valid_o = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) begin
      ptr_d = (32'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arb_sram.sv
// Multi-port on-chip memory: round-robin arbitration, byte-enabled writes, 1- or 2-cycle
// read latency and a sticky write lock that turns the array into a boot ROM.
module mem_arb_sram
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_WORDS    = 1024,
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "",
  localparam int unsigned AW = addr_width(NUM_WORDS),
  localparam int unsigned BW = lane_count(DATA_WIDTH)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0]                  we_i,
  input  logic [NUM_PORTS-1:0][AW-1:0]          addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_PORTS-1:0][BW-1:0]          be_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic [NUM_PORTS-1:0]                  err_o,
  input  logic                                  lock_i,
  output logic                                  locked_o
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  // Contents survive rst_i; they are only set at time zero.
  initial begin
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      mem_q[i] = '0;
    end
  end

  logic [NUM_PORTS-1:0] gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_valid;

  rr_arbiter #(
    .N(NUM_PORTS)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign gnt_o = gnt;

  logic                  locked_q, locked_d;
  logic                  acc_we;
  logic [AW-1:0]         acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [DATA_WIDTH-1:0] acc_mask;
  logic                  acc_oob;
  logic                  do_write;
  rsp_t                  acc_rsp;

  always_comb begin
    acc_we    = we_i[gnt_idx];
    acc_addr  = addr_i[gnt_idx];
    acc_wdata = wdata_i[gnt_idx];
    // Lane b covers bits [8b +: 8]; the top lane may be partial.
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      acc_mask[i] = be_i[gnt_idx][i / 8];
    end
    acc_oob  = 32'(acc_addr) >= NUM_WORDS;
    do_write = gnt_valid && acc_we && !acc_oob && !locked_q;
    acc_rsp  = '0;
    if (acc_we) begin
      acc_rsp.err = (acc_oob || locked_q) ? ErrAccess : ErrNone;
    end else begin
      acc_rsp.err = acc_oob ? ErrAccess : ErrNone;
      if (!acc_oob) begin
        acc_rsp.rdata[DATA_WIDTH-1:0] = mem_q[acc_addr];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem_q[acc_addr] <= (mem_q[acc_addr] & ~acc_mask) | (acc_wdata & acc_mask);
    end
  end

  // A write granted in the same cycle as lock_i still sees the old, unlocked state.
  always_comb begin
    locked_d = locked_q | lock_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end

  logic          fin_valid;
  logic [PW-1:0] fin_port;
  rsp_t          fin_rsp;

  if (READ_LATENCY == 2) begin : g_lat2
    logic          s1_valid_q, s1_valid_d;
    logic [PW-1:0] s1_port_q, s1_port_d;
    rsp_t          s1_rsp_q, s1_rsp_d;

    always_comb begin
      s1_valid_d = gnt_valid;
      s1_port_d  = gnt_idx;
      s1_rsp_d   = acc_rsp;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s1_valid_q <= 1'b0;
        s1_port_q  <= '0;
        s1_rsp_q   <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_port_q  <= s1_port_d;
        s1_rsp_q   <= s1_rsp_d;
      end
    end

    assign fin_valid = s1_valid_q;
    assign fin_port  = s1_port_q;
    assign fin_rsp   = s1_rsp_q;
  end else begin : g_lat1
    assign fin_valid = gnt_valid;
    assign fin_port  = gnt_idx;
    assign fin_rsp   = acc_rsp;
  end

  // Per-port output registers so each port keeps its last rdata/err between responses.
  logic [NUM_PORTS-1:0]                 rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0]                 err_q, err_d;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = '0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    if (fin_valid) begin
      rvalid_d[fin_port] = 1'b1;
      err_d[fin_port]    = fin_rsp.err;
      rdata_d[fin_port]  = fin_rsp.rdata[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign locked_o = locked_q;

endmodule

// File: tb/tb_mem_arb_sram.sv
// Bench for mem_arb_sram: a 3-port, 20-bit, 1000-word, latency-2 instance under random
// and directed traffic against a queue-based model, plus a 1-port latency-1 instance.
module tb_mem_arb_sram;

  localparam int ADw = 20;
  localparam int ANw = 1000;
  localparam int ANp = 3;
  localparam int ALat = 2;
  localparam int AAw = 10;
  localparam int ABw = 3;
  localparam int BDw = 32;
  localparam int BNw = 12;
  localparam int BAw = 4;
  localparam int BBw = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_a;
  logic [ANp-1:0]            a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [ANp-1:0][AAw-1:0]   a_addr;
  logic [ANp-1:0][ADw-1:0]   a_wdata, a_rdata;
  logic [ANp-1:0][ABw-1:0]   a_be;
  logic                      a_lock, a_locked;

  logic                      rst_b;
  logic [0:0]                b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [0:0][BAw-1:0]       b_addr;
  logic [0:0][BDw-1:0]       b_wdata, b_rdata;
  logic [0:0][BBw-1:0]       b_be;
  logic                      b_lock, b_locked;

  mem_arb_sram #(
    .DATA_WIDTH   (ADw),
    .NUM_WORDS    (ANw),
    .NUM_PORTS    (ANp),
    .READ_LATENCY (ALat),
    .INIT_FILE    ("")
  ) dut_a (
    .clk_i    (clk),
    .rst_i    (rst_a),
    .req_i    (a_req),
    .we_i     (a_we),
    .addr_i   (a_addr),
    .wdata_i  (a_wdata),
    .be_i     (a_be),
    .gnt_o    (a_gnt),
    .rvalid_o (a_rvalid),
    .rdata_o  (a_rdata),
    .err_o    (a_err),
    .lock_i   (a_lock),
    .locked_o (a_locked)
  );

  mem_arb_sram #(
    .DATA_WIDTH   (BDw),
    .NUM_WORDS    (BNw),
    .NUM_PORTS    (1),
    .READ_LATENCY (1),
    .INIT_FILE    ("")
  ) dut_b (
    .clk_i    (clk),
    .rst_i    (rst_b),
    .req_i    (b_req),
    .we_i     (b_we),
    .addr_i   (b_addr),
    .wdata_i  (b_wdata),
    .be_i     (b_be),
    .gnt_o    (b_gnt),
    .rvalid_o (b_rvalid),
    .rdata_o  (b_rdata),
    .err_o    (b_err),
    .lock_i   (b_lock),
    .locked_o (b_locked)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model for dut_a: memory image, pointer, lock and a queue of due responses.
  typedef struct {
    int             due;
    int             port;
    logic [ADw-1:0] rdata;
    bit             err;
  } exp_t;

  logic [ADw-1:0] m_mem [ANw];
  int             m_ptr;
  bit             m_locked;
  logic [ADw-1:0] m_last_rdata [ANp];
  bit             m_last_err [ANp];
  exp_t           m_q [$];
  int             cyc = 0;

  function automatic logic [ADw-1:0] lane_mask(input logic [ABw-1:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int l = 0; l < ABw; l++) begin
      if (be[l]) m = m | (32'hFF << (8 * l));
    end
    return m[ADw-1:0];
  endfunction

  task automatic step_a(output int g);
    exp_t           e;
    logic [ANp-1:0] exp_gnt;
    logic [ADw-1:0] mk;
    bit             exp_v;
    g       = -1;
    exp_gnt = '0;
    #1;
    for (int i = 0; i < ANp; i++) begin
      int p;
      p = (m_ptr + i) % ANp;
      if (g < 0 && a_req[p]) g = p;
    end
    if (g >= 0) exp_gnt[g] = 1'b1;
    check_eq("gnt", 64'(a_gnt), 64'(exp_gnt));
    if (g >= 0) begin
      e.due   = cyc + ALat;
      e.port  = g;
      e.rdata = '0;
      e.err   = 1'b0;
      if (int'(a_addr[g]) >= ANw) begin
        e.err = 1'b1;
      end else if (a_we[g]) begin
        if (m_locked) begin
          e.err = 1'b1;
        end else begin
          mk = lane_mask(a_be[g]);
          m_mem[a_addr[g]] = (m_mem[a_addr[g]] & ~mk) | (a_wdata[g] & mk);
        end
      end else begin
        e.rdata = m_mem[a_addr[g]];
      end
      m_q.push_back(e);
      m_ptr = (g + 1) % ANp;
    end
    if (a_lock) m_locked = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < ANp; p++) begin
      exp_v = (m_q.size() > 0) && (m_q[0].due == cyc) && (m_q[0].port == p);
      if (exp_v) begin
        m_last_rdata[p] = m_q[0].rdata;
        m_last_err[p]   = m_q[0].err;
      end
      check_eq($sformatf("rvalid[%0d]", p), 64'(a_rvalid[p]), 64'(exp_v));
      check_eq($sformatf("rdata[%0d]", p), 64'(a_rdata[p]), 64'(m_last_rdata[p]));
      check_eq($sformatf("err[%0d]", p), 64'(a_err[p]), 64'(m_last_err[p]));
    end
    if (m_q.size() > 0 && m_q[0].due == cyc) void'(m_q.pop_front());
    check_eq("locked", 64'(a_locked), 64'(m_locked));
  endtask

  task automatic op_a(input int p, input bit we, input int addr, input logic [ADw-1:0] wd,
                      input logic [ABw-1:0] be);
    int g;
    a_req       = '0;
    a_req[p]    = 1'b1;
    a_we[p]     = we;
    a_addr[p]   = AAw'(addr);
    a_wdata[p]  = wd;
    a_be[p]     = be;
    step_a(g);
    a_req = '0;
  endtask

  task automatic idle_a(input int n);
    int g;
    a_req = '0;
    repeat (n) step_a(g);
  endtask

  task automatic reset_a();
    a_req  = '0;
    a_lock = 1'b0;
    rst_a  = 1'b1;
    #1;
    check_eq("rst_rvalid", 64'(a_rvalid), 64'h0);
    check_eq("rst_rdata", 64'(a_rdata), 64'h0);
    check_eq("rst_err", 64'(a_err), 64'h0);
    check_eq("rst_locked", 64'(a_locked), 64'h0);
    a_req = '1;
    #1;
    check_eq("rst_gnt", 64'(a_gnt), 64'h0);
    a_req = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rvalid_hold", 64'(a_rvalid), 64'h0);
    @(negedge clk);
    rst_a = 1'b0;
    m_q.delete();
    m_ptr    = 0;
    m_locked = 1'b0;
    for (int p = 0; p < ANp; p++) begin
      m_last_rdata[p] = '0;
      m_last_err[p]   = 1'b0;
    end
  endtask

  task automatic rand_phase(input int n, input int lock_at);
    int g;
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < ANp; p++) begin
        if (!a_req[p] && $urandom_range(0, 2) != 0) begin
          a_req[p]   = 1'b1;
          a_we[p]    = 1'($urandom_range(0, 1));
          a_addr[p]  = AAw'(($urandom_range(0, 9) == 0) ? $urandom_range(995, 1023)
                                                        : $urandom_range(0, 7));
          a_wdata[p] = ADw'($urandom);
          a_be[p]    = ABw'($urandom);
        end
      end
      a_lock = (c == lock_at);
      step_a(g);
      a_lock = 1'b0;
      if (g >= 0) a_req[g] = 1'b0;
    end
  endtask

  task automatic op_b(input bit we, input int addr, input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] exp_rd, input bit exp_err, input string tag);
    b_req   = 1'b1;
    b_we    = we;
    b_addr  = BAw'(addr);
    b_wdata = wd;
    b_be    = be;
    #1;
    check_eq({tag, "_gnt"}, 64'(b_gnt), 64'h1);
    @(posedge clk);
    #1;
    b_req  = 1'b0;
    b_lock = 1'b0;
    check_eq({tag, "_rvalid"}, 64'(b_rvalid), 64'h1);
    check_eq({tag, "_rdata"}, 64'(b_rdata), 64'(exp_rd));
    check_eq({tag, "_err"}, 64'(b_err), 64'(exp_err));
  endtask

  initial begin
    int g;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0; a_lock = 1'b0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '0; b_lock = 1'b0;
    rst_b = 1'b1;
    for (int i = 0; i < ANw; i++) m_mem[i] = '0;

    reset_a();
    rst_b = 1'b0;

    // Three ports requesting continuously: grants rotate 0,1,2,0,1,2.
    a_req = '1;
    a_we  = '0;
    for (int p = 0; p < ANp; p++) a_addr[p] = AAw'(p + 1);
    repeat (6) step_a(g);
    idle_a(3);

    // Partial top lane on a zeroed word.
    op_a(0, 1'b1, 3, 20'hFFFFF, 3'b100);
    op_a(0, 1'b0, 3, '0, '0);
    // Out-of-range read, then back-to-back reads.
    op_a(1, 1'b0, 1000, '0, '0);
    op_a(1, 1'b0, 1, '0, '0);
    op_a(2, 1'b0, 2, '0, '0);
    idle_a(3);

    // Reset one cycle after a read grant; array contents must survive.
    op_a(2, 1'b0, 3, '0, '0);
    reset_a();
    op_a(2, 1'b0, 3, '0, '0);
    idle_a(3);

    rand_phase(300, -1);
    rand_phase(200, 100);
    a_req = '0;
    idle_a(4);

    // Single-port, latency-1 instance.
    @(negedge clk);
    op_b(1'b1, 5, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "b_w_full");
    op_b(1'b1, 5, 32'h000000AA, 4'h1, 32'h0, 1'b0, "b_w_lane0");
    op_b(1'b0, 5, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, "b_r_merge");
    op_b(1'b1, 5, 32'h12345678, 4'h0, 32'h0, 1'b0, "b_w_be0");
    op_b(1'b0, 5, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, "b_r_be0");
    op_b(1'b0, 13, 32'h0, 4'h0, 32'h0, 1'b1, "b_r_oob");
    @(posedge clk);
    #1;
    check_eq("b_idle_rvalid", 64'(b_rvalid), 64'h0);
    check_eq("b_idle_err_hold", 64'(b_err), 64'h1);
    op_b(1'b1, 0, 32'h1234, 4'hF, 32'h0, 1'b0, "b_w_pre_lock");
    b_lock = 1'b1;
    op_b(1'b1, 1, 32'h55, 4'hF, 32'h0, 1'b0, "b_w_with_lock");
    check_eq("b_locked", 64'(b_locked), 64'h1);
    op_b(1'b1, 0, 32'hFFFF, 4'hF, 32'h0, 1'b1, "b_w_locked");
    op_b(1'b0, 0, 32'h0, 4'h0, 32'h1234, 1'b0, "b_r_after_lock");
    op_b(1'b0, 1, 32'h0, 4'h0, 32'h55, 1'b0, "b_r_lock_cycle");
    rst_b = 1'b1;
    #1;
    check_eq("b_rst_locked", 64'(b_locked), 64'h0);
    check_eq("b_rst_rdata", 64'(b_rdata), 64'h0);
    @(negedge clk);
    rst_b = 1'b0;
    op_b(1'b0, 0, 32'h0, 4'h0, 32'h1234, 1'b0, "b_r_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
